// File: rtl/react_pkg.sv
// Shared widths, limits, view encodings and divider states for reaction_stats.
package react_pkg;
  localparam int TIME_W   = 10;
  localparam int SUM_W    = 14;
  localparam int CNT_W    = 4;
  localparam int MAX_TIME = 999;

  localparam logic [1:0] SEL_LAST = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_MAX  = 2'b10;
  localparam logic [1:0] SEL_AVG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t,
                                                  input logic [TIME_W-1:0] ceil);
    return (t > ceil) ? ceil : t;
  endfunction
endpackage

// File: rtl/stats_div.sv
// Restoring divider, one quotient bit per cycle; a new start restarts from iteration 0.
// state   | meaning
// ST_IDLE | waiting for start
// ST_DIV  | SUM_W iterations, iter counts down to 0
// ST_DONE | quotient final, done high for this cycle
module stats_div
  import react_pkg::*;
(
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SUM_W-1:0]  dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic [TIME_W-1:0] quotient,
  output logic              done,
  output logic              busy
);
  div_state_e       state, state_nxt;
  logic [SUM_W-1:0] dvd;
  logic [CNT_W-1:0] dvs, rem, iter;
  logic [CNT_W:0]   trial;
  logic             fits;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort)      state_nxt = ST_IDLE;
    else if (start) state_nxt = ST_DIV;
    else begin
      case (state)
        ST_DIV:  if (iter == '0) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  assign trial = {rem, dvd[SUM_W-1]};
  assign fits  = (trial >= {1'b0, dvs});

  // Only the low TIME_W quotient bits are kept; the average never exceeds MAX_TIME.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      iter     <= '0;
      quotient <= '0;
    end else if (start && !abort) begin
      dvd      <= dividend;
      dvs      <= divisor;
      rem      <= '0;
      iter     <= CNT_W'(SUM_W - 1);
      quotient <= '0;
    end else if (state == ST_DIV) begin
      dvd      <= dvd << 1;
      rem      <= fits ? CNT_W'(trial - {1'b0, dvs}) : trial[CNT_W-1:0];
      quotient <= {quotient[TIME_W-2:0], fits};
      iter     <= iter - CNT_W'(1);
    end
  end
endmodule

// File: rtl/reaction_stats.sv
// Reaction-time statistics: last/min/max/average of accepted results plus a foul counter.
// Define REACT_STATS_ROUND_EN to round the average half-up instead of truncating it.
module reaction_stats #(
  parameter int MAX_TIME = react_pkg::MAX_TIME,
  parameter int CNT_MAX  = 15
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          res_valid,
  input  logic [react_pkg::TIME_W-1:0]  res_time,
  input  logic                          res_foul,
  input  logic [1:0]                    sel,
  output logic [react_pkg::TIME_W-1:0]  stat_out,
  output logic                          stat_valid,
  output logic [react_pkg::CNT_W-1:0]   count,
  output logic [react_pkg::CNT_W-1:0]   foul_cnt,
  output logic                          busy
);
  import react_pkg::*;

  localparam logic [TIME_W-1:0] TIME_CEIL = TIME_W'(MAX_TIME);
  localparam logic [CNT_W-1:0]  CNT_LIM   = CNT_W'(CNT_MAX);

  logic [TIME_W-1:0] last_r, min_r, max_r, avg_r, clamped, div_q;
  logic [SUM_W-1:0]  sum_r, sum_nxt, dividend;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept, foul, upd, div_done;

  assign accept  = res_valid && !res_foul && !clear;
  assign foul    = res_valid &&  res_foul && !clear;
  assign upd     = accept && (count != CNT_LIM);
  assign clamped = clamp_time(res_time, TIME_CEIL);
  assign sum_nxt = sum_r + SUM_W'(clamped);
  assign cnt_nxt = count + CNT_W'(1);

`ifdef REACT_STATS_ROUND_EN
  assign dividend = sum_nxt + SUM_W'(cnt_nxt >> 1);
`else
  assign dividend = sum_nxt;
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      last_r   <= '0;
      min_r    <= TIME_CEIL;
      max_r    <= '0;
      sum_r    <= '0;
      count    <= '0;
      foul_cnt <= '0;
      avg_r    <= '0;
    end else if (clear) begin
      last_r   <= '0;
      min_r    <= TIME_CEIL;
      max_r    <= '0;
      sum_r    <= '0;
      count    <= '0;
      foul_cnt <= '0;
      avg_r    <= '0;
    end else begin
      if (accept) last_r <= clamped;
      if (upd) begin
        if (count == '0 || clamped <= min_r) min_r <= clamped;
        if (count == '0 || clamped >= max_r) max_r <= clamped;
        sum_r <= sum_nxt;
        count <= cnt_nxt;
      end
      if (foul && foul_cnt != '1) foul_cnt <= foul_cnt + CNT_W'(1);
      // A restart landing on the DONE cycle supersedes the finishing division.
      if (div_done && !upd) avg_r <= div_q;
    end
  end

  stats_div u_div (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .start    (upd),
    .abort    (clear),
    .dividend (dividend),
    .divisor  (cnt_nxt),
    .quotient (div_q),
    .done     (div_done),
    .busy     (busy)
  );

  always_comb begin
    stat_out   = '0;
    stat_valid = 1'b0;
    if (count != '0) begin
      stat_valid = 1'b1;
      case (sel)
        SEL_LAST: stat_out = last_r;
        SEL_MIN:  stat_out = min_r;
        SEL_MAX:  stat_out = max_r;
        default: begin
          stat_out   = avg_r;
          stat_valid = !busy;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reaction_stats.sv
// Bench for reaction_stats: directed cases with literal expectations plus random traffic
// compared every cycle against a queue-based model of the accepted results.
module tb_reaction_stats;
  localparam int MAXT = 999;
  localparam int CMAX = 15;
`ifdef REACT_STATS_ROUND_EN
  localparam int AVG3 = 247;
`else
  localparam int AVG3 = 246;
`endif

  logic       clk_50M = 1'b0;
  logic       rst_n, clear, res_valid, res_foul;
  logic [9:0] res_time, stat_out;
  logic [1:0] sel;
  logic       stat_valid, busy;
  logic [3:0] count, foul_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model: accepted values, last result, foul count, published average and pending division.
  int acc_q[$];
  int m_last, m_avg, m_fouls, pend_val, pend_left;
  bit pending;

  reaction_stats #(.MAX_TIME(MAXT), .CNT_MAX(CMAX)) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .clear      (clear),
    .res_valid  (res_valid),
    .res_time   (res_time),
    .res_foul   (res_foul),
    .sel        (sel),
    .stat_out   (stat_out),
    .stat_valid (stat_valid),
    .count      (count),
    .foul_cnt   (foul_cnt),
    .busy       (busy)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic int q_sum();
    int s = 0;
    foreach (acc_q[i]) s += acc_q[i];
    return s;
  endfunction

  function automatic int q_min();
    int m = MAXT;
    foreach (acc_q[i]) if (acc_q[i] < m) m = acc_q[i];
    return m;
  endfunction

  function automatic int q_max();
    int m = 0;
    foreach (acc_q[i]) if (acc_q[i] > m) m = acc_q[i];
    return m;
  endfunction

  function automatic int avg_of(input int s, input int c);
`ifdef REACT_STATS_ROUND_EN
    return (s + c / 2) / c;
`else
    return s / c;
`endif
  endfunction

  task automatic model_reset();
    acc_q.delete();
    m_last = 0; m_avg = 0; m_fouls = 0;
    pending = 0; pend_left = 0; pend_val = 0;
  endtask

  // Average appears 16 cycles after the accepting pulse; a newer accepted result replaces it.
  task automatic model_step();
    bit started = 0;
    if (clear) begin
      model_reset();
    end else if (res_valid && res_foul) begin
      if (m_fouls < 15) m_fouls++;
    end else if (res_valid) begin
      m_last = (int'(res_time) > MAXT) ? MAXT : int'(res_time);
      if (acc_q.size() < CMAX) begin
        acc_q.push_back(m_last);
        pend_val  = avg_of(q_sum(), acc_q.size());
        pend_left = 15;
        pending   = 1;
        started   = 1;
      end
    end
    if (pending && !started) begin
      pend_left--;
      if (pend_left == 0) begin
        m_avg   = pend_val;
        pending = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    int n     = acc_q.size();
    int e_out = 0;
    int e_vld = 0;
    if (n > 0) begin
      e_vld = 1;
      case (sel)
        2'd0:    e_out = m_last;
        2'd1:    e_out = q_min();
        2'd2:    e_out = q_max();
        default: begin e_out = m_avg; e_vld = pending ? 0 : 1; end
      endcase
    end
    check("count",      int'(count),      n);
    check("foul_cnt",   int'(foul_cnt),   m_fouls);
    check("busy",       int'(busy),       int'(pending));
    check("stat_out",   int'(stat_out),   e_out);
    check("stat_valid", int'(stat_valid), e_vld);
  endtask

  task automatic tick();
    @(posedge clk_50M);
    if (rst_n) model_step();
    @(negedge clk_50M);
    cmp_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int t, input bit f);
    res_valid = 1'b1; res_time = 10'(t); res_foul = f;
    tick();
    res_valid = 1'b0; res_foul = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic lit(input string name, input logic [1:0] s, input int exp);
    sel = s;
    #1;
    check(name, int'(stat_out), exp);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; res_valid = 1'b0; res_time = '0; res_foul = 1'b0; sel = 2'd0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    tick();
    check("rst_count", int'(count), 0);
    lit("rst_avg_view", 2'd3, 0);
    check("rst_valid", int'(stat_valid), 0);

    // 250, 180, 310
    pulse(250, 0); idle(1); pulse(180, 0); idle(1); pulse(310, 0);
    idle(14);
    check("avg3_busy_t15", int'(busy), 1);
    check("avg3_invalid_t15", int'(stat_valid), 0);
    idle(1);
    check("avg3_busy_t16", int'(busy), 0);
    check("avg3_valid_t16", int'(stat_valid), 1);
    lit("avg3", 2'd3, AVG3);
    lit("min3", 2'd1, 180);
    lit("max3", 2'd2, 310);
    lit("last3", 2'd0, 310);
    check("count3", int'(count), 3);

    // 200, foul, 200
    do_clear();
    pulse(200, 0); idle(2); pulse(200, 1); idle(2); pulse(200, 0);
    idle(15);
    check("foul1", int'(foul_cnt), 1);
    check("count2", int'(count), 2);
    lit("avg200", 2'd3, 200);
    lit("last200", 2'd0, 200);

    // clamp
    do_clear();
    pulse(1023, 0); idle(2);
    lit("clamp_last", 2'd0, 999);
    lit("clamp_max", 2'd2, 999);

    // saturation of accumulation
    do_clear();
    for (int i = 0; i < 16; i++) pulse(100, 0);
    pulse(500, 0);
    idle(15);
    check("sat_count", int'(count), 15);
    lit("sat_max", 2'd2, 100);
    lit("sat_last", 2'd0, 500);
    lit("sat_avg", 2'd3, 100);

    // restart while busy
    do_clear();
    sel = 2'd3;
    pulse(300, 0); idle(4); pulse(100, 0);
    idle(9);
    check("restart_busy_a", int'(busy), 1);
    idle(1);
    check("restart_busy_b", int'(busy), 1);
    idle(4);
    check("restart_busy_c", int'(busy), 1);
    idle(1);
    check("restart_done", int'(busy), 0);
    lit("restart_avg", 2'd3, 200);

    // clear wins over a simultaneous result
    clear = 1'b1; res_valid = 1'b1; res_time = 10'd500;
    tick();
    clear = 1'b0; res_valid = 1'b0;
    check("clr_count", int'(count), 0);
    check("clr_busy", int'(busy), 0);
    lit("clr_out", 2'd0, 0);
    check("clr_valid", int'(stat_valid), 0);
    idle(20);
    check("clr_still_idle", int'(busy), 0);

    // reset in the middle of a division
    pulse(400, 0); idle(5);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_count", int'(count), 0);
    lit("rst_mid_out", 2'd3, 0);
    tick();
    rst_n = 1'b1;
    idle(20);
    check("rst_no_restart", int'(busy), 0);
    pulse(600, 0); idle(3);
    lit("rst_no_stale_avg", 2'd3, 0);
    idle(13);
    lit("rst_new_avg", 2'd3, 600);

    // foul counter saturates at 15
    do_clear();
    for (int i = 0; i < 17; i++) pulse(0, 1);
    check("foul_sat", int'(foul_cnt), 15);
    check("foul_sat_count", int'(count), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      sel       = 2'($urandom_range(0, 3));
      clear     = ($urandom_range(0, 199) == 0);
      res_valid = ($urandom_range(0, 5) == 0);
      res_foul  = ($urandom_range(0, 4) == 0);
      res_time  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(990, 1023))
                                              : 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reaction_stats.md
REACTION_STATS -- requirements
Module: reaction_stats

Interface
REQ-001 SHALL take parameter MAX_TIME, default 999, as the saturation ceiling for result values.
REQ-002 SHALL take parameter CNT_MAX, default 15, as the maximum number of results accumulated.
REQ-003 SHALL have port clk_50M, input, 1 bit: the single 50 MHz clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous history clear; already debounced; level-sensitive.
REQ-006 SHALL have port res_valid, input, 1 bit: one-cycle pulse from the timing logic marking a new result.
REQ-007 SHALL have port res_time, input, 10 bits: reaction time in ms; sampled when res_valid=1.
REQ-008 SHALL have port res_foul, input, 1 bit: foul flag; sampled when res_valid=1.
REQ-009 SHALL have port sel, input, 2 bits: output view; 00 last, 01 min, 10 max, 11 avg.
REQ-010 SHALL have port stat_out, output, 10 bits: the selected statistic (combinational mux of registered values).
REQ-011 SHALL have port stat_valid, output, 1 bit: 1 when count>0 and, for sel=11, the average is not stale.
REQ-012 SHALL have port count, output, 4 bits: number of accepted non-foul results.
REQ-013 SHALL have port foul_cnt, output, 4 bits: number of fouls; saturates at 15.
REQ-014 SHALL have port busy, output, 1 bit: average division in progress.

Function
REQ-015 SHALL, when res_valid=1 and res_foul=0, clamp res_time to MAX_TIME, then update last, min, max, sum and count in the next cycle.
REQ-016 SHALL treat a foul (res_valid=1, res_foul=1) as incrementing foul_cnt only; last, min, max, sum, count and avg are unchanged.
REQ-017 SHALL compute min/max with inclusive compare; the first accepted result sets both min and max.
REQ-018 SHALL size sum at 14 bits (15 × 999 = 14985); overflow is impossible by construction.
REQ-019 SHALL, once count=CNT_MAX, update only last on further non-foul results and leave min, max, sum and count frozen.
REQ-020 SHALL run a divider FSM with states IDLE -> DIV (14 iterations) -> DONE -> IDLE; start is triggered by each sum update.
REQ-021 SHALL, for a result pulsed in cycle t, hold busy=1 in cycles t+1..t+15 and make the new avg visible at t+16; stat_valid for sel=11 is 0 while busy.
REQ-022 SHALL, when res_valid arrives while busy, accept the result and restart DIV from iteration 0 with the new sum and count.
REQ-023 SHALL compute avg = floor(sum/count), unless the rounding macro is defined.
REQ-024 SHALL drive stat_out=0 and stat_valid=0 when count=0, regardless of sel.
REQ-025 SHALL give clear priority over a simultaneous res_valid (the result is dropped); clear zeroes all statistics and returns the FSM to IDLE.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force last=0, min=MAX_TIME (internal), max=0, sum=0, count=0, foul_cnt=0, avg=0, busy=0, FSM=IDLE, stat_out=0 and stat_valid=0.
REQ-027 SHALL abort any in-progress division on reset without producing an avg update.

Configuration
REQ-028 SHALL, when REACT_STATS_ROUND_EN is defined, compute avg = floor((sum + count/2)/count) (round-half-up); when it is undefined, compute floor(sum/count). Latency is identical in both builds.

Structure
REQ-029 SHALL place TIME_W=10, SUM_W=14, MAX_TIME and the sel encodings (SEL_LAST, SEL_MIN, SEL_MAX, SEL_AVG) in shared package react_pkg.
REQ-030 SHALL implement the restoring divider as sub-module stats_div with ports start, dividend[13:0], divisor[3:0], quotient[9:0], done and busy.

Verification
REQ-031 SHALL cover: results 250, 180, 310 (no fouls) -> count=3, min=180, max=310, avg=246 (247 with REACT_STATS_ROUND_EN), avg visible 16 cycles after the last pulse.
REQ-032 SHALL cover: a foul pulse between two results of 200 -> foul_cnt=1, count=2, avg=200, last=200.
REQ-033 SHALL cover: res_time=1023 -> last=999 and max=999.
REQ-034 SHALL cover: 16 results of 100 followed by one result of 500 -> count=15, max=100, last=500, avg=100.
REQ-035 SHALL cover: a second res_valid 5 cycles after the first -> busy stays 1 and the avg reflects both results 16 cycles after the second pulse.
REQ-036 SHALL cover: clear and res_valid in the same cycle, and rst_n low mid-DIV -> all outputs are 0, stat_valid=0 and no avg update occurs afterwards.
